// File: rtl/ctr_pkg.sv
// Shared constants for the count sequencer: default counter width and the
// legacy-compatible state encodings used by the controller FSM.
package ctr_pkg;

  localparam int CTR_WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_HOLD = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  function automatic logic state_is_busy(input state_t s);
    return (s == ST_RUN) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/count_seq_ctrl_if.sv
// Control/status bundle between the count sequencer (slave) and its
// requester (master).
interface count_seq_ctrl_if #(
  parameter int WIDTH = ctr_pkg::CTR_WIDTH
);
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             upper;
  logic             busy;
  logic             done;

  modport master (
    output start, pause, limit,
    input  count, upper, busy, done
  );

  modport slave (
    input  start, pause, limit,
    output count, upper, busy, done
  );
endinterface

// File: rtl/counter_en.sv
// WIDTH-bit up counter with asynchronous reset, synchronous clear and
// count enable; clear wins over enable.
module counter_en #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/count_seq_ctrl.sv
// Run sequencer: counts from 0 up to a limit captured at start, with pause
// support and a one-cycle done pulse at the end of each run.
module count_seq_ctrl
  import ctr_pkg::*;
#(
  parameter int WIDTH = CTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  count_seq_ctrl_if.slave       bus
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_lim;
  logic [WIDTH-1:0] w_count;
  logic             w_clr;
  logic             w_en;
  logic             w_capture;
  logic             w_term;

  counter_en #(.WIDTH(WIDTH)) u_counter (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .o_count(w_count)
  );

  // Terminal check is tested before pause so a run never stalls at its limit.
  assign w_term = (w_count == r_lim);

  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    w_en         = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_next = ST_RUN;
          w_clr        = 1'b1;
          w_capture    = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_term) begin
          w_state_next = ST_DONE;
        end else if (bus.pause) begin
          w_state_next = ST_HOLD;
        end else begin
          w_en = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!bus.pause) begin
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_clr        = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_lim   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_lim <= bus.limit;
      end
    end
  end

  assign bus.count = w_count;
  assign bus.upper = w_count[WIDTH-1];
  assign bus.busy  = state_is_busy(r_state);
  assign bus.done  = (r_state == ST_DONE);

endmodule

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, counter width in bits.
REQ-002 Port: clk  input  1  clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: start  input  1  request a counting run; sampled only in IDLE.
REQ-005 Port: pause  input  1  freeze counting while high; honoured only in RUN/HOLD.
REQ-006 Port: limit  input  WIDTH  terminal count; captured on the accepted start edge.
REQ-007 Port: count  output  WIDTH  current count value, registered.
REQ-008 Port: upper  output  1  high when count is in the upper half of its range (count[WIDTH-1]).
REQ-009 Port: busy  output  1  high in RUN or HOLD.
REQ-010 Port: done  output  1  one-cycle pulse marking end of run.

Function
REQ-011 States SHALL be IDLE, RUN, HOLD, DONE; all outputs registered or decoded from registered state/count only.
REQ-012 IDLE: count held at 0; start=1 at edge -> RUN, lim_q <= limit, count <= 0.
REQ-013 IDLE with start=0 SHALL remain IDLE; start in any other state SHALL be ignored.
REQ-014 RUN: count==lim_q at edge -> DONE, count unchanged; else pause=1 -> HOLD, count unchanged; else count <= count+1.
REQ-015 Terminal detection SHALL take priority over pause on the same edge.
REQ-016 HOLD: count frozen; pause=0 at edge -> RUN (no increment on that edge); pause=1 -> stay HOLD.
REQ-017 DONE: lasts exactly one cycle, done=1; next edge -> IDLE, count <= 0.
REQ-018 Run length: with limit L, RUN occupies L+1 cycles (excluding HOLD cycles); done asserts L+1 edges after the start edge.
REQ-019 limit=0: run SHALL reach DONE on the first RUN edge, count never leaves 0.
REQ-020 count SHALL never wrap; maximum value reached is lim_q (limit=2^WIDTH-1 reaches 15 then DONE).
REQ-021 Changes on limit after the start edge SHALL have no effect on the current run.
REQ-022 upper SHALL equal count[WIDTH-1] combinationally (high for 8..15 at WIDTH=4).
REQ-023 busy=1 exactly in RUN and HOLD; done=1 exactly in DONE.

Reset
REQ-024 rst=1 SHALL asynchronously force state IDLE, count=0, lim_q=0, done=0, busy=0, upper=0.
REQ-025 rst asserted mid-run (RUN/HOLD/DONE) SHALL abort the run with no done pulse.
REQ-026 After rst deasserts, the first start SHALL be accepted at the next rising edge.

Structure
REQ-027 State encodings (IDLE=0, RUN=1, HOLD=2, DONE=3) and default WIDTH SHALL live in shared package ctr_pkg.
REQ-028 The counting register SHALL be a sub-module counter_en (WIDTH-bit up counter: async reset, synchronous clear, enable); count_seq_ctrl holds only FSM, lim_q and compare.
REQ-029 Terminal compare SHALL be a single equality of count against lim_q.

Verification
REQ-030 rst pulse, then limit=3, start 1 cycle -> count 0,1,2,3 on successive edges; done=1 one cycle at edge 4; count=0, busy=0 at edge 5.
REQ-031 limit=12, start; pause high for 3 cycles when count=5 -> count holds 5 for 3 cycles, resumes 6; done at count 12; upper=1 from count=8.
REQ-032 limit=0, start -> busy 1 cycle, done pulse next cycle, count stays 0.
REQ-033 limit=15, start -> count reaches 15, upper=1, done pulse, no wrap to 0 before DONE.
REQ-034 limit=9, start; rst asserted asynchronously at count=6 -> count=0, busy=0 immediately, no done pulse; new start accepted after release.
REQ-035 Run with limit=4; change limit to 1 and pulse start during RUN -> both ignored, done at count 4; pause and count==lim_q same edge -> DONE.
